hsk_src: RTL and testbench
==========================

HSK_SRC -- requirements
Module: hsk_src

Interface
REQ-001 Parameter: WIDTH, default 8, width of the transferred data word.
REQ-002 Parameter: TIMEOUT_CYCLES, default 255, cycles waited per handshake phase before flagging timeout; legal range 4..65535.
REQ-003 Port: clk_src  input  1  source-domain clock; all logic on its rising edge.
REQ-004 Port: rst_src  input  1  reset; the block has one clock, and this reset is synchronous and active-high.
REQ-005 Port: src_valid  input  1  local producer has a word to send.
REQ-006 Port: src_ready  output  1  block accepts a word this cycle.
REQ-007 Port: src_data  input  WIDTH  word to send; sampled on accept.
REQ-008 Port: req_async  output  1  registered request level toward the destination domain.
REQ-009 Port: data_async  output  WIDTH  registered data bus toward the destination domain.
REQ-010 Port: ack_async  input  1  acknowledge level from the destination domain; asynchronous to clk_src.
REQ-011 Port: busy  output  1  a handshake is in progress.
REQ-012 Port: timeout_err  output  1  sticky handshake-timeout flag.

Function
REQ-013 ack_async SHALL pass through exactly two clk_src flops (ack_sync) before any use; no other logic touches ack_async.
REQ-014 FSM states SHALL be IDLE, REQ_HI (req asserted, awaiting ack_sync=1) and REQ_LO (req released, awaiting ack_sync=0).
REQ-015 src_ready SHALL equal (state==IDLE) && !ack_sync; a stale-high ack blocks acceptance.
REQ-016 Accept (src_valid && src_ready at edge N) SHALL load data_async with src_data and move to REQ_HI; req_async SHALL be 1 from edge N+1.
REQ-017 data_async SHALL change only on accept and SHALL remain stable through REQ_HI and REQ_LO.
REQ-018 In REQ_HI, on the first cycle ack_sync==1, the FSM SHALL move to REQ_LO and req_async SHALL be 0 from the following edge.
REQ-019 In REQ_LO, on the first cycle ack_sync==0, the FSM SHALL return to IDLE; a back-to-back accept is possible on the next cycle.
REQ-020 Minimum handshake, with ack echoing req after 1 cycle: accept to next src_ready SHALL be no more than 8 cycles.
REQ-021 busy SHALL equal (state != IDLE).
REQ-022 src_valid deasserted, or src_data changing, while the block is not ready SHALL have no effect.
REQ-023 A glitch-free ack pulse shorter than 2 clk_src cycles is a protocol violation; behaviour is then undefined but SHALL NOT deadlock the state machine past a reset.

Reset
REQ-024 rst_src high at an edge SHALL force state=IDLE, req_async=0, data_async=0, both ack sync flops=0 and timeout_err=0, regardless of state; reset mid-handshake abandons the transfer.
REQ-025 The first acceptance after reset release SHALL be possible at the first edge with rst_src=0 and src_valid=1, provided ack_sync=0.

Configuration
REQ-026 Macro HSK_SRC_TIMEOUT_EN defined: a phase counter SHALL clear on every state change and increment each cycle in REQ_HI/REQ_LO; when it reaches TIMEOUT_CYCLES, timeout_err SHALL set and hold until reset; the FSM SHALL keep waiting (no abort).
REQ-027 Macro HSK_SRC_TIMEOUT_EN undefined: no counter SHALL be instantiated, and timeout_err SHALL be tied to 0.

Verification
REQ-028 Reset, then src_valid=1 and src_data=8'hA5 with ack looped back after 3 cycles -> data_async=8'hA5 and req_async=1 one edge after accept, req_async=0 after ack_sync rises, src_ready=1 again after ack falls.
REQ-029 Back-to-back words 8'h01, 8'h02 and 8'h03 with continuous src_valid -> exactly 3 handshakes, data_async sequence 01, 02, 03, each held stable while req_async=1.
REQ-030 ack_async held at 1 from reset release -> src_ready stays 0; drop ack -> src_ready=1 three cycles later.
REQ-031 rst_src pulsed for 1 cycle while in REQ_HI -> next edge shows req_async=0, data_async=0, busy=0.
REQ-032 With HSK_SRC_TIMEOUT_EN and TIMEOUT_CYCLES=10, ack never returns -> timeout_err=1 after 10 cycles in REQ_HI and stays 1 with req_async still 1; without the macro -> timeout_err stays 0.
REQ-033 Random ack delays of 0-20 cycles over 1000 words -> every word is delivered once, in order, and no req_async edge occurs while data_async changes.

Source files
------------

// File: rtl/hsk_src.sv
// hsk_src: source side of a four-phase req/ack clock-domain-crossing handshake.
// A word accepted from the local producer is held on data_async while
// req_async is raised; the destination echoes the request level on ack_async,
// which is brought into clk_src through a two-flop synchroniser.
// Optional build macro: HSK_SRC_TIMEOUT_EN adds a per-phase watchdog that sets a
// sticky timeout_err when a phase lasts TIMEOUT_CYCLES cycles; without it,
// timeout_err is tied low.
//
// state  | meaning
// IDLE   | no transfer; accept when src_valid and ack_sync is low
// REQ_HI | req_async high, waiting for ack_sync to rise
// REQ_LO | req_async low, waiting for ack_sync to fall
module hsk_src #(
  parameter int WIDTH          = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk_src,
  input  logic             rst_src,
  input  logic             src_valid,
  output logic             src_ready,
  input  logic [WIDTH-1:0] src_data,
  output logic             req_async,
  output logic [WIDTH-1:0] data_async,
  input  logic             ack_async,
  output logic             busy,
  output logic             timeout_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ_HI = 2'd1,
    REQ_LO = 2'd2
  } state_t;

  state_t           state_q;
  logic             ack_meta_q;
  logic             ack_sync_q;
  logic             req_q;
  logic [WIDTH-1:0] data_q;
  logic             accept;

  assign src_ready  = (state_q == IDLE) && !ack_sync_q;
  assign accept     = src_valid && src_ready;
  assign busy       = (state_q != IDLE);
  assign req_async  = req_q;
  assign data_async = data_q;

  // Two-flop synchroniser: the only place ack_async is touched.
  always_ff @(posedge clk_src) begin
    if (rst_src) begin
      ack_meta_q <= 1'b0;
      ack_sync_q <= 1'b0;
    end else begin
      ack_meta_q <= ack_async;
      ack_sync_q <= ack_meta_q;
    end
  end

  // Handshake FSM with registered request and data outputs.
  always_ff @(posedge clk_src) begin
    if (rst_src) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            data_q  <= src_data;
            req_q   <= 1'b1;
            state_q <= REQ_HI;
          end
        end
        REQ_HI: begin
          if (ack_sync_q) begin
            req_q   <= 1'b0;
            state_q <= REQ_LO;
          end
        end
        REQ_LO: begin
          if (!ack_sync_q) begin
            state_q <= IDLE;
          end
        end
        default: begin
          // Unused encoding: recover to a clean idle rather than lock up.
          req_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef HSK_SRC_TIMEOUT_EN
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic        err_q;
  logic        phase_done;

  assign phase_done = ((state_q == IDLE)   && accept)      ||
                      ((state_q == REQ_HI) && ack_sync_q)  ||
                      ((state_q == REQ_LO) && !ack_sync_q);

  // Phase counter: cleared on every state change, saturates at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if ((state_q == IDLE) || phase_done) begin
      cnt_d = '0;
    end else if (cnt_q != TO_LIMIT) begin
      cnt_d = 16'(cnt_q + 16'd1);
    end
  end

  // Counter register and sticky timeout flag; the FSM keeps waiting.
  always_ff @(posedge clk_src) begin
    if (rst_src) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (cnt_d == TO_LIMIT) begin
        err_q <= 1'b1;
      end
    end
  end

  assign timeout_err = err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign timeout_err        = 1'b0;
`endif

endmodule

// File: tb/tb_hsk_src.sv
// tb_hsk_src: directed and randomised-delay checks of hsk_src against a
// protocol-level reference model and an in-order delivery scoreboard.
module tb_hsk_src;

  localparam int W  = 8;
  localparam int TO = 10;
`ifdef HSK_SRC_TIMEOUT_EN
  localparam logic TO_EN = 1'b1;
`else
  localparam logic TO_EN = 1'b0;
`endif

  logic         clk_src = 1'b0;
  logic         rst_src;
  logic         src_valid;
  logic         src_ready;
  logic [W-1:0] src_data;
  logic         req_async;
  logic [W-1:0] data_async;
  logic         ack_async;
  logic         busy;
  logic         timeout_err;

  hsk_src #(.WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk_src    (clk_src),
    .rst_src    (rst_src),
    .src_valid  (src_valid),
    .src_ready  (src_ready),
    .src_data   (src_data),
    .req_async  (req_async),
    .data_async (data_async),
    .ack_async  (ack_async),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 clk_src = ~clk_src;

  int n_pass = 0;
  int n_chk  = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: protocol phase, visible ack history, words sent.
  int           m_phase;   // 0 idle, 1 waiting for ack high, 2 waiting for ack low
  logic         m_a1, m_a2; // ack level one and two edges ago
  logic         m_req, m_err;
  logic [W-1:0] m_data;
  int           m_wait;
  logic [W-1:0] sent_q[$];
  logic [W-1:0] dlv_q[$];

  always @(posedge clk_src) begin
    if (rst_src) begin
      m_phase <= 0; m_a1 <= 1'b0; m_a2 <= 1'b0;
      m_req <= 1'b0; m_data <= '0; m_err <= 1'b0; m_wait <= 0;
    end else begin
      m_a1 <= ack_async;
      m_a2 <= m_a1;
      if (m_phase == 0 && src_valid && !m_a2) begin
        sent_q.push_back(src_data);
        m_data <= src_data; m_req <= 1'b1; m_phase <= 1; m_wait <= 0;
      end else if (m_phase == 1 && m_a2) begin
        m_req <= 1'b0; m_phase <= 2; m_wait <= 0;
      end else if (m_phase == 2 && !m_a2) begin
        m_phase <= 0; m_wait <= 0;
      end else if (m_phase != 0) begin
        if (TO_EN && m_wait + 1 >= TO) m_err <= 1'b1;
        m_wait <= m_wait + 1;
      end
    end
  end

  logic         prev_req  = 1'b0;
  logic [W-1:0] prev_data = '0;

  // Single compare process: outputs vs model, delivery order, data stability.
  always @(negedge clk_src) begin
    if (chk_en) begin
      check("src_ready",   {31'd0, src_ready},   {31'd0, (m_phase == 0) && !m_a2});
      check("req_async",   {31'd0, req_async},   {31'd0, m_req});
      check("data_async",  {24'd0, data_async},  {24'd0, m_data});
      check("busy",        {31'd0, busy},        {31'd0, m_phase != 0});
      check("timeout_err", {31'd0, timeout_err}, {31'd0, m_err});
      if (req_async && !prev_req) begin
        if (sent_q.size() == 0) check("dlv_unexpected", 32'd1, 32'd0);
        else begin
          check("dlv_order", {24'd0, data_async}, {24'd0, sent_q.pop_front()});
          dlv_q.push_back(data_async);
        end
      end
      if (prev_req && req_async)
        check("data_stable", {24'd0, data_async}, {24'd0, prev_data});
      prev_req  <= req_async;
      prev_data <= data_async;
    end
  end

  // Destination emulator: echo req onto ack after a delay.
  logic auto_en = 1'b0;
  logic rand_en = 1'b0;
  int   fixed_dly = 0;
  int   dly_left  = 0;

  task automatic cycle();
    @(posedge clk_src);
    #1;
    if (auto_en && (req_async != ack_async)) begin
      if (dly_left == 0) begin
        ack_async = req_async;
        dly_left  = rand_en ? int'($urandom_range(20, 0)) : fixed_dly;
      end else begin
        dly_left--;
      end
    end
  endtask

  task automatic wait_ready(input int maxc, output int n);
    n = 0;
    while (!src_ready && n < maxc) begin cycle(); n++; end
    check("ready_bound", {31'd0, src_ready}, 32'd1);
  endtask

  task automatic do_reset();
    rst_src = 1'b1; cycle(); cycle(); rst_src = 1'b0;
  endtask

  int n, d0, words, cyc;

  initial begin
    rst_src = 1'b1; src_valid = 1'b0; src_data = '0; ack_async = 1'b0;
    cycle(); chk_en = 1'b1; cycle();
    check("rst_req",   {31'd0, req_async}, 32'd0);
    check("rst_data",  {24'd0, data_async}, 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);

    // Single word, ack 3 cycles after each req edge; accept on first free edge.
    rst_src = 1'b0; auto_en = 1'b1; fixed_dly = 3; dly_left = 3;
    src_valid = 1'b1; src_data = 8'hA5;
    cycle();
    src_valid = 1'b0;
    check("a5_req",   {31'd0, req_async}, 32'd1);
    check("a5_data",  {24'd0, data_async}, 32'hA5);
    check("a5_ready", {31'd0, src_ready}, 32'd0);
    wait_ready(50, n);
    check("a5_latency", n, 32'd12);
    check("a5_req_lo",  {31'd0, req_async}, 32'd0);

    // Immediate echo: minimum handshake length.
    fixed_dly = 0; dly_left = 0;
    src_valid = 1'b1; src_data = 8'h77;
    cycle();
    src_valid = 1'b0;
    wait_ready(50, n);
    check("min_latency", n, 32'd6);

    // Back-to-back words; junk data while not ready must be ignored.
    d0 = dlv_q.size();
    src_valid = 1'b1;
    for (int w = 1; w <= 3; w++) begin
      n = 0;
      while (!src_ready && n < 50) begin src_data = 8'hEE; cycle(); n++; end
      src_data = W'(w);
      cycle();
    end
    src_valid = 1'b0;
    wait_ready(50, n);
    check("b2b_count", dlv_q.size() - d0, 32'd3);
    if (dlv_q.size() >= d0 + 3) begin
      check("b2b_w0", {24'd0, dlv_q[d0]},     32'h01);
      check("b2b_w1", {24'd0, dlv_q[d0 + 1]}, 32'h02);
      check("b2b_w2", {24'd0, dlv_q[d0 + 2]}, 32'h03);
    end

    // Stale-high ack blocks acceptance until it has been seen low.
    auto_en = 1'b0; ack_async = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++) cycle();
    check("stale_ready", {31'd0, src_ready}, 32'd0);
    ack_async = 1'b0;
    cycle();
    check("drop_ready1", {31'd0, src_ready}, 32'd0);
    cycle(); cycle();
    check("drop_ready3", {31'd0, src_ready}, 32'd1);

    // Reset pulse while waiting in the request-high phase.
    src_valid = 1'b1; src_data = 8'h5A;
    cycle();
    src_valid = 1'b0;
    cycle(); cycle();
    check("hi_busy", {31'd0, busy}, 32'd1);
    rst_src = 1'b1; cycle(); rst_src = 1'b0;
    check("mid_rst_req",  {31'd0, req_async}, 32'd0);
    check("mid_rst_data", {24'd0, data_async}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);

    // Ack never returns: watchdog flags after TO cycles and FSM keeps waiting.
    src_valid = 1'b1; src_data = 8'h3C;
    cycle();
    src_valid = 1'b0;
    for (int i = 0; i < 9; i++) cycle();
    check("to_before", {31'd0, timeout_err}, 32'd0);
    cycle();
    check("to_at",     {31'd0, timeout_err}, {31'd0, TO_EN});
    for (int i = 0; i < 20; i++) cycle();
    check("to_hold",   {31'd0, timeout_err}, {31'd0, TO_EN});
    check("to_req",    {31'd0, req_async}, 32'd1);
    do_reset();
    check("to_clear",  {31'd0, timeout_err}, 32'd0);

    // 1000 words with random ack delays of 0..20 cycles.
    auto_en = 1'b1; rand_en = 1'b1; dly_left = int'($urandom_range(20, 0));
    d0 = dlv_q.size(); words = 0; cyc = 0;
    src_valid = 1'b1; src_data = W'($urandom);
    while (words < 1000 && cyc < 60000) begin
      if (src_ready) begin
        cycle(); words++; src_data = W'($urandom);
      end else begin
        if ($urandom_range(1, 0) == 1) src_data = W'($urandom);
        cycle();
      end
      cyc++;
    end
    src_valid = 1'b0;
    wait_ready(200, n);
    check("rnd_words",   words, 32'd1000);
    check("rnd_dlv",     dlv_q.size() - d0, 32'd1000);
    check("rnd_pending", sent_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
